// File: rtl/fir_pkg.sv
// Shared definitions for the filter decimation buffer: default sample width,
// FSM state encoding and the saturating absolute-value helper.
package fir_pkg;

  localparam int FIR_DATA_W = 9;

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // |x| for a two's-complement sample; the most-negative code clamps to max positive.
  function automatic logic [FIR_DATA_W-1:0] sat_abs(input logic [FIR_DATA_W-1:0] x);
    logic [FIR_DATA_W-1:0] w_mag;
    if (x == {1'b1, {(FIR_DATA_W-1){1'b0}}}) begin
      w_mag = {1'b0, {(FIR_DATA_W-1){1'b1}}};
    end else if (x[FIR_DATA_W-1]) begin
      w_mag = (~x) + FIR_DATA_W'(1);
    end else begin
      w_mag = x;
    end
    return w_mag;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Generic DEPTH x DATA_W synchronous FIFO with registered show-ahead output.
// A push while full is accepted only when a pop happens in the same cycle.
module fir_sync_fifo #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_dout;

  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_rd_nxt;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == (ADDR_W+1)'(DEPTH));
  assign w_pop    = i_pop && !o_empty;
  assign w_push   = i_push && (!o_full || w_pop);
  assign w_rd_nxt = w_pop ? r_rd_ptr + ADDR_W'(1) : r_rd_ptr;
  assign o_dout   = r_dout;
  assign o_count  = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // dout preloads the entry rd_ptr will point at after this edge; when that
  // entry is the one being written now, take it straight from the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      r_rd_ptr <= w_rd_nxt;
      if (w_push && (r_wr_ptr == w_rd_nxt)) begin
        r_dout <= i_din;
      end else begin
        r_dout <= r_mem[w_rd_nxt];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fir_decim_buffer.sv
// Drops the filter fill transient, decimates by DECIM and buffers kept samples
// behind a valid/ready port. Define FIR_PEAK_DETECT_EN to add the peak_abs output.
module fir_decim_buffer
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DECIM  = 2,
  parameter int SKIP   = 3,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_en,
  input  logic [DATA_W-1:0] din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_ovf
`ifdef FIR_PEAK_DETECT_EN
  ,
  output logic [DATA_W-1:0] peak_abs
`endif
);

  localparam int SKIP_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam state_t RST_STATE = (SKIP == 0) ? S_RUN : S_FILL;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SKIP_W-1:0] r_skip;
  logic [PH_W-1:0]   r_phase;
  logic              r_overflow;

  logic              w_keep;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;

  always_comb begin
    w_state_nxt = r_state;
    w_keep      = 1'b0;
    case (r_state)
      S_FILL: begin
        if (in_en && (r_skip == SKIP_W'(SKIP - 1))) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_keep = in_en && (r_phase == '0);
      end
      default: w_state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RST_STATE;
      r_skip  <= '0;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_FILL) && in_en) begin
        r_skip <= r_skip + SKIP_W'(1);
      end
      if ((r_state == S_RUN) && in_en) begin
        r_phase <= (r_phase == PH_W'(DECIM - 1)) ? '0 : r_phase + PH_W'(1);
      end
    end
  end

  fir_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_keep),
    .i_pop   (out_ready),
    .i_din   (din),
    .o_dout  (dout),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  assign w_drop    = w_keep && w_full && !w_pop;
  assign overflow  = r_overflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef FIR_PEAK_DETECT_EN
  logic [DATA_W-1:0] r_peak;
  logic [DATA_W-1:0] w_abs;
  logic              w_push_acc;

  assign w_abs      = sat_abs(din);
  assign w_push_acc = w_keep && !w_drop;
  assign peak_abs   = r_peak;

  // A clear coinciding with a push restarts tracking from the new sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_peak <= '0;
    end else if (w_push_acc) begin
      if (clr_ovf || (w_abs > r_peak)) begin
        r_peak <= w_abs;
      end
    end else if (clr_ovf) begin
      r_peak <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Self-checking bench for fir_decim_buffer against a queue-based reference model.
module tb_fir_decim_buffer;

  localparam int DATA_W = 9;
  localparam int DECIM  = 2;
  localparam int SKIP   = 3;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_en = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] dout;
  logic [3:0]        count;
  logic              overflow;
  logic              clr_ovf = 1'b0;
`ifdef FIR_PEAK_DETECT_EN
  logic [DATA_W-1:0] peak_abs;
`endif

  fir_decim_buffer #(
    .DATA_W (DATA_W),
    .DECIM  (DECIM),
    .SKIP   (SKIP),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_en     (in_en),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
`ifdef FIR_PEAK_DETECT_EN
    ,
    .peak_abs  (peak_abs)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: strobes counted since reset, a plain queue for the FIFO.
  logic [DATA_W-1:0] m_q[$];
  int                m_strobes = 0;
  bit                m_ovf = 1'b0;
  int                m_peak = 0;

  function automatic bit kept_at(input int idx);
    return (idx >= SKIP) && (((idx - SKIP) % DECIM) == 0);
  endfunction

  function automatic int abs_sat(input logic [DATA_W-1:0] d);
    int v;
    v = int'($signed(d));
    if (v < 0) v = -v;
    if (v > 255) v = 255;
    return v;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_strobes = 0;
    m_ovf     = 1'b0;
    m_peak    = 0;
  endtask

  task automatic cyc(input bit en, input logic [DATA_W-1:0] d, input bit rdy, input bit clr);
    bit pop, keep, push;
    in_en     = en;
    din       = d;
    out_ready = rdy;
    clr_ovf   = clr;
    @(posedge clk);
    pop  = (m_q.size() != 0) && rdy;
    keep = en && kept_at(m_strobes);
    if (en) m_strobes++;
    push = keep && ((m_q.size() < DEPTH) || pop);
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(d);
    if (keep && !push) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (push) begin
      if (clr || (abs_sat(d) > m_peak)) m_peak = abs_sat(d);
    end else if (clr) begin
      m_peak = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    n_checks++;
    if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++;
    if (dout !== '0) begin n_fail++; $display("FAIL reset_dout got %0d want 0", dout); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", overflow); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_fill_decim();
    logic [DATA_W-1:0] exp_out[5] = '{9'd4, 9'd6, 9'd8, 9'd10, 9'd12};
    logic [DATA_W-1:0] got[$];
    for (int i = 1; i <= 15; i++) begin
      cyc(i <= 12, (i <= 12) ? DATA_W'(i) : '0, 1'b1, 1'b0);
      if (i == 3) begin
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_skip_valid got %0b want 0", out_valid); end
      end
      if (i == 4) begin
        n_checks++;
        if (out_valid !== 1'b1 || dout !== 9'd4)
          begin n_fail++; $display("FAIL fill_first_latency got v=%0b d=%0d want v=1 d=4", out_valid, dout); end
      end
      if (out_valid === 1'b1) got.push_back(dout);
    end
    n_checks++;
    if (got.size() != 5) begin n_fail++; $display("FAIL fill_out_count got %0d want 5", got.size()); end
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      n_checks++;
      if (got[k] !== exp_out[k]) begin n_fail++; $display("FAIL fill_out[%0d] got %0d want %0d", k, got[k], exp_out[k]); end
    end
  endtask

  task automatic test_overflow();
    int kept = 0;
    logic [DATA_W-1:0] head;
    for (int i = 0; i < 40 && kept < 9; i++) begin
      if (kept_at(m_strobes)) kept++;
      cyc(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
      if (kept == 8 && kept_at(m_strobes - 1)) begin
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %0b want 0", overflow); end
      end
    end
    n_checks++;
    if (count !== 4'd8) begin n_fail++; $display("FAIL ovf_count got %0d want 8", count); end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %0b want 1", overflow); end
    head = m_q[0];
    n_checks++;
    if (dout !== head) begin n_fail++; $display("FAIL ovf_head got %0d want %0d", dout, head); end
    cyc(1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %0b want 0", overflow); end
    n_checks++;
    if (count !== 4'd8 || dout !== head)
      begin n_fail++; $display("FAIL ovf_clear_keep got c=%0d d=%0d want c=8 d=%0d", count, dout, head); end
    cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_full_push_pop();
    logic [DATA_W-1:0] d;
    if (!kept_at(m_strobes)) cyc(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    d = DATA_W'($urandom);
    cyc(1'b1, d, 1'b1, 1'b0);
    n_checks++;
    if (count !== 4'd8) begin n_fail++; $display("FAIL fpp_count got %0d want 8", count); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf got %0b want 0", overflow); end
    n_checks++;
    if (m_q[7] !== d) begin n_fail++; $display("FAIL fpp_model_tail got %0d want %0d", m_q[7], d); end
    for (int i = 0; i < 10; i++) begin
      if (m_q.size() != 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || dout !== m_q[0])
          begin n_fail++; $display("FAIL fpp_drain got v=%0b d=%0d want v=1 d=%0d", out_valid, dout, m_q[0]); end
      end
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    n_checks++;
    if (out_valid !== 1'b0 || count !== 4'd0)
      begin n_fail++; $display("FAIL fpp_empty got v=%0b c=%0d want v=0 c=0", out_valid, count); end
  endtask

  task automatic test_strobe_gaps();
    int q_before;
    for (int i = 0; i < 24; i++) begin
      q_before = m_q.size();
      cyc((i % 2) == 0, DATA_W'($urandom), (i % 6) > 2, 1'b0);
      n_checks++;
      if (count !== 4'(m_q.size()) || out_valid !== (m_q.size() != 0))
        begin n_fail++; $display("FAIL gaps_count[%0d] got c=%0d v=%0b want c=%0d", i, count, out_valid, m_q.size()); end
      if (m_q.size() != 0) begin
        n_checks++;
        if (dout !== m_q[0]) begin n_fail++; $display("FAIL gaps_dout[%0d] got %0d want %0d", i, dout, m_q[0]); end
      end
      if ((i % 2) == 1 && (i % 6) <= 2) begin
        n_checks++;
        if (count !== 4'(q_before)) begin n_fail++; $display("FAIL gaps_idle[%0d] got %0d want %0d", i, count, q_before); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 30 && m_q.size() < 5; i++) cyc(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd5) begin n_fail++; $display("FAIL mid_prefill got %0d want 5", count); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || count !== 4'd0)
      begin n_fail++; $display("FAIL mid_async got v=%0b c=%0d want v=0 c=0", out_valid, count); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < SKIP; i++) begin
      cyc(1'b1, DATA_W'(i + 100), 1'b1, 1'b0);
      n_checks++;
      if (count !== 4'd0) begin n_fail++; $display("FAIL mid_skip[%0d] got %0d want 0", i, count); end
    end
    cyc(1'b1, 9'd77, 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd1 || dout !== 9'd77)
      begin n_fail++; $display("FAIL mid_first got c=%0d d=%0d want c=1 d=77", count, dout); end
  endtask

`ifdef FIR_PEAK_DETECT_EN
  task automatic test_peak();
    logic [DATA_W-1:0] seq[10];
    int                exp_pk[10];
    seq    = '{9'd200, 9'd250, 9'd180, 9'd10, 9'd255, 9'h138, 9'd255, 9'h100, 9'd254, 9'd50};
    exp_pk = '{0, 0, 0, 10, 10, 200, 200, 255, 255, 255};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, seq[i], 1'b1, 1'b0);
      n_checks++;
      if (peak_abs !== DATA_W'(exp_pk[i]))
        begin n_fail++; $display("FAIL peak[%0d] got %0d want %0d", i, peak_abs, exp_pk[i]); end
    end
    cyc(1'b0, '0, 1'b1, 1'b1);
    n_checks++;
    if (peak_abs !== '0) begin n_fail++; $display("FAIL peak_clear got %0d want 0", peak_abs); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, DATA_W'($urandom), $urandom_range(0, 2) == 0,
          $urandom_range(0, 15) == 0);
      n_checks++;
      if (count !== 4'(m_q.size()) || out_valid !== (m_q.size() != 0))
        begin n_fail++; $display("FAIL rnd_count[%0d] got c=%0d v=%0b want c=%0d", i, count, out_valid, m_q.size()); end
      if (m_q.size() != 0) begin
        n_checks++;
        if (dout !== m_q[0]) begin n_fail++; $display("FAIL rnd_dout[%0d] got %0d want %0d", i, dout, m_q[0]); end
      end
      n_checks++;
      if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf[%0d] got %0b want %0b", i, overflow, m_ovf); end
`ifdef FIR_PEAK_DETECT_EN
      n_checks++;
      if (peak_abs !== DATA_W'(m_peak))
        begin n_fail++; $display("FAIL rnd_peak[%0d] got %0d want %0d", i, peak_abs, m_peak); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fill_decim();
    test_overflow();
    test_full_push_pop();
    test_strobe_gaps();
    test_reset_midstream();
`ifdef FIR_PEAK_DETECT_EN
    test_peak();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
